pipeline_sequencer: RTL and testbench

//  Central pipeline controller for the 5-stage core. Takes hazard requests (ID data-hazard

---
 rtl/pipeline_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Central 5-stage pipeline controller: prioritises memory wait, redirect and data-hazard
// stall into per-stage enables/flushes, with a dmem watchdog and saturating perf counters.
module pipeline_sequencer #(
  parameter int unsigned CNT_WIDTH        = 32,
  parameter int unsigned MEM_TIMEOUT      = 16,
  parameter int unsigned REDIRECT_BUBBLES = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 stall_req,
  input  logic                 flush_req,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_flush,
  output logic                 id_ex_en,
  output logic                 id_ex_flush,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 mem_err,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int unsigned TimerW = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned RcntW  = $clog2(REDIRECT_BUBBLES + 1);

  localparam logic [TimerW-1:0] TimerLimit = TimerW'(MEM_TIMEOUT);
  localparam logic [RcntW-1:0]  RcntInit   = RcntW'(REDIRECT_BUBBLES - 1);

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StMemWait  = 2'd1,
    StRedirect = 2'd2,
    StError    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [RcntW-1:0]      rcnt_q, rcnt_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic memwait;
  logic run_decide;
  logic [TimerW-1:0] timer_inc;

  assign memwait   = dmem_req & ~dmem_ready;
  assign timer_inc = timer_q + TimerW'(1);

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    state_d     = state_q;
    timer_d     = timer_q;
    rcnt_d      = rcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    run_decide  = 1'b0;

    unique case (state_q)
      StRun: run_decide = 1'b1;
      StMemWait: begin
        if (memwait) begin
          timer_d = timer_inc;
          if (timer_inc == TimerLimit) state_d = StError;
        end else begin
          run_decide = 1'b1;
        end
      end
      StRedirect: begin
        // Frozen by memory: keep the pending bubble and its flush, do not count down
        if_id_flush = 1'b1;
        if (!memwait) begin
          pc_en     = 1'b1;
          if_id_en  = 1'b1;
          id_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          rcnt_d    = rcnt_q - RcntW'(1);
          if (rcnt_q <= RcntW'(1)) state_d = StRun;
        end
      end
      StError: ;
      default: state_d = StError;
    endcase

    if (run_decide) begin
      state_d = StRun;
      if (memwait) begin
        state_d = StMemWait;
        timer_d = TimerW'(1);
      end else if (flush_req) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if (~&flush_cnt_q) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        if (REDIRECT_BUBBLES > 1) begin
          state_d = StRedirect;
          rcnt_d  = RcntInit;
        end
      end else if (stall_req) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if (~&stall_cnt_q) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    end

    // Pipeline must be quiescent while reset is held
    if (!rstn) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StRun;
      timer_q     <= '0;
      rcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rcnt_q      <= rcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = (state_q == StError);
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_sequencer;

  localparam int unsigned CW   = 4;
  localparam int unsigned MT   = 16;
  localparam int unsigned RB   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          stall_req, flush_req, dmem_req, dmem_ready;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic          mem_err;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_sequencer #(
    .CNT_WIDTH       (CW),
    .MEM_TIMEOUT     (MT),
    .REDIRECT_BUBBLES(RB)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall_req  (stall_req),
    .flush_req  (flush_req),
    .dmem_req   (dmem_req),
    .dmem_ready (dmem_ready),
    .pc_en      (pc_en),
    .if_id_en   (if_id_en),
    .if_id_flush(if_id_flush),
    .id_ex_en   (id_ex_en),
    .id_ex_flush(id_ex_flush),
    .ex_mem_en  (ex_mem_en),
    .mem_wb_en  (mem_wb_en),
    .mem_err    (mem_err),
    .state      (state),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bubbles still owed to IF/ID, consecutive memory-wait cycles, dead-on-timeout flag
  int m_bub, m_wait, m_scnt, m_fcnt;
  bit m_dead;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_bub  = 0;
    m_wait = 0;
    m_scnt = 0;
    m_fcnt = 0;
    m_dead = 1'b0;
  endtask

  // One clock cycle: drive after the edge, check at the falling edge, then advance the model
  task automatic step(input bit rn, input bit s, input bit f, input bit r, input bit y);
    bit e_pc, e_ifen, e_iff, e_idex, e_idf, e_exm, e_mwb;
    int exp_state;
    @(posedge clk);
    #1;
    rstn       = rn;
    stall_req  = s;
    flush_req  = f;
    dmem_req   = r;
    dmem_ready = y;
    @(negedge clk);
    if (!rn) model_clear();
    exp_state = m_dead ? 3 : (m_wait > 0) ? 1 : (m_bub > 0) ? 2 : 0;
    chk("state", 32'(state), 32'(exp_state));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
    chk("mem_err", 32'(mem_err), 32'(m_dead));

    {e_pc, e_ifen, e_iff, e_idex, e_idf, e_exm, e_mwb} = '0;
    if (!rn || m_dead) begin
      // everything off
    end else if (r && !y) begin
      e_iff = (m_bub > 0);
      if (m_bub == 0) begin
        m_wait++;
        if (m_wait == MT) m_dead = 1'b1;
      end
    end else if (m_bub > 0) begin
      {e_pc, e_ifen, e_idex, e_exm, e_mwb} = '1;
      e_iff = 1'b1;
      m_bub--;
    end else begin
      m_wait = 0;
      if (f) begin
        {e_pc, e_ifen, e_iff, e_idex, e_idf, e_exm, e_mwb} = '1;
        if (m_fcnt < CMAX) m_fcnt++;
        m_bub = RB - 1;
      end else if (s) begin
        {e_idex, e_idf, e_exm, e_mwb} = '1;
        if (m_scnt < CMAX) m_scnt++;
      end else begin
        {e_pc, e_ifen, e_idex, e_exm, e_mwb} = '1;
      end
    end
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("if_id_en", 32'(if_id_en), 32'(e_ifen));
    chk("if_id_flush", 32'(if_id_flush), 32'(e_iff));
    chk("id_ex_en", 32'(id_ex_en), 32'(e_idex));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
    chk("ex_mem_en", 32'(ex_mem_en), 32'(e_exm));
    chk("mem_wb_en", 32'(mem_wb_en), 32'(e_mwb));
  endtask

  initial begin
    int burst;
    bit s, f, r, y;
    rstn = 1'b0;
    {stall_req, flush_req, dmem_req, dmem_ready} = '0;
    model_clear();

    // Reset held 3 cycles with inputs toggling: everything quiet
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0], ~i[0], 1'b1, i[1]);
      chk("rst_outputs",
          32'({pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en,
               mem_err}), 32'd0);
    end
    step(1'b1, 0, 0, 0, 0);
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_pc_en", 32'(pc_en), 32'd1);

    // Three stall cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1, 0, 0, 0);
      chk("stall_pc_en", 32'(pc_en), 32'd0);
      chk("stall_id_ex_flush", 32'(id_ex_flush), 32'd1);
    end
    step(1'b1, 0, 0, 0, 0);
    chk("stall_cnt_3", 32'(stall_cnt), 32'd3);

    // One redirect with two bubbles
    step(1'b1, 0, 1, 0, 0);
    chk("redir_c0_flushes", 32'({if_id_flush, id_ex_flush}), 32'd3);
    step(1'b1, 0, 0, 0, 0);
    chk("redir_c1_state", 32'(state), 32'd2);
    chk("redir_c1_if_id_flush", 32'(if_id_flush), 32'd1);
    step(1'b1, 0, 0, 0, 0);
    chk("redir_c2_state", 32'(state), 32'd0);
    chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);

    // Five-cycle memory wait then completion
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 0, 0, 1, 0);
      chk("memwait_pc_en", 32'(pc_en), 32'd0);
    end
    step(1'b1, 0, 0, 1, 1);
    chk("memready_pc_en", 32'(pc_en), 32'd1);
    step(1'b1, 0, 0, 0, 0);
    chk("memready_state", 32'(state), 32'd0);

    // Flush and stall together: flush wins, stall not counted
    step(1'b1, 1, 1, 0, 0);
    chk("fs_flushes", 32'({if_id_flush, id_ex_flush, pc_en}), 32'd7);
    step(1'b1, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0);
    chk("fs_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("fs_flush_cnt", 32'(flush_cnt), 32'd2);

    // Saturation of the 4-bit stall counter
    for (int i = 0; i < 20; i++) step(1'b1, 1, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0);
    chk("stall_cnt_sat", 32'(stall_cnt), 32'd15);

    // Watchdog: 16 wait cycles end in ERROR, sticky until reset
    for (int i = 0; i < 16; i++) step(1'b1, 0, 0, 1, 0);
    step(1'b1, 0, 0, 0, 0);
    chk("timeout_state", 32'(state), 32'd3);
    chk("timeout_mem_err", 32'(mem_err), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1, 0, 1);
    chk("error_sticky", 32'({mem_err, pc_en}), 32'd2);
    step(1'b0, 0, 0, 0, 0);
    chk("error_rst_clear", 32'({mem_err, state}), 32'd0);

    // Randomized traffic with occasional long memory stalls and resets
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom % 4) == 0;
      f = ($urandom % 6) == 0;
      r = ($urandom % 3) == 0;
      y = ($urandom % 4) != 0;
      if ((m_dead && ($urandom % 4) == 0) || ($urandom % 500) == 0) begin
        burst = 0;
        step(1'b0, s, f, r, y);
      end else if (burst > 0) begin
        burst--;
        step(1'b1, s, f, 1, 0);
      end else begin
        if (($urandom % 40) == 0) burst = $urandom_range(2, 20);
        step(1'b1, s, f, r, y);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
